dsp_mac_sequencer: RTL

//  Upstream control stage for one DSP48A1 slice (A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1).

---
 rtl/dsp_mac_pkg.sv | 26 ++
 rtl/dsp_mac_token_pipe.sv | 30 +++
 rtl/dsp_mac_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 dot-product sequencer.
package dsp_mac_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // OPMODE values: X=M with Z=0 restarts the sum, X=M with Z=P accumulates.
   localparam logic [7:0] OPM_MUL_ONLY = 8'h01;
   localparam logic [7:0] OPM_MUL_ACC  = 8'h09;

   // Cycles from operand accept to updated P, and from accept to the OPMODE slot.
   localparam int MAC_LAT = 3;
   localparam int OPM_DLY = 1;

   // One token per accepted operand pair, tracking it through the M and P slots.
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
   } tok_t;

endpackage

// File: rtl/dsp_mac_token_pipe.sv
// Shift register of {valid, first, last} tokens that lines up clock enables
// with the slice's internal register stages. Synchronous clear drops all tokens.
module dsp_mac_token_pipe
   import dsp_mac_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  tok_t                i_tok,
   output tok_t [STAGES-1:0]   o_tok
);

   tok_t [STAGES-1:0] r_tok;

   // Advance tokens one slot per cycle; index 0 is the slot right after accept.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tok <= '0;
      end else begin
         r_tok[0] <= i_tok;
         for (int i = 1; i < STAGES; i++) begin
            r_tok[i] <= r_tok[i-1];
         end
      end
   end

   assign o_tok = r_tok;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Control stage for one DSP48A1 slice computing an unsigned dot product.
// Operands pass straight to the slice A/B pins; tokens drive CEM/CEOPMODE/CEP,
// and the final P is captured into a held valid/ready result register.
module dsp_mac_sequencer
   import dsp_mac_pkg::*;
#(
   parameter int WIDTH_2 = 18,
   parameter int WIDTH_4 = 48,
   parameter int LEN_W   = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_2-1:0] in_a,
   input  logic [WIDTH_2-1:0] in_b,
   input  logic               in_last,
   output logic [WIDTH_2-1:0] dsp_a,
   output logic [WIDTH_2-1:0] dsp_b,
   output logic               dsp_cea,
   output logic               dsp_ceb,
   output logic               dsp_cem,
   output logic               dsp_ceopmode,
   output logic [7:0]         dsp_opmode,
   output logic               dsp_cep,
   input  logic [WIDTH_4-1:0] dsp_p,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_4-1:0] out_data,
   output logic [LEN_W-1:0]   out_len
);

   localparam int TOK_STAGES = MAC_LAT - OPM_DLY;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      return (&v) ? v : v + LEN_W'(1);
   endfunction

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_in_ready;
   logic                    w_accept;
   logic                    w_first;
   tok_t                    w_tok_in;
   tok_t [TOK_STAGES-1:0]   w_tok;
   logic                    r_cap_p2;
   logic [7:0]              r_opmode;
   logic [LEN_W-1:0]        r_count;
   logic                    r_out_valid;
   logic [WIDTH_4-1:0]      r_out_data;
   logic [LEN_W-1:0]        r_out_len;
   logic                    w_unused_tok;

   // Ready is forced low while reset is held so nothing is accepted then.
   assign in_ready = r_in_ready & ~RST;
   assign w_accept = in_valid & in_ready;
   assign w_first  = (r_state == S_IDLE);
   assign w_tok_in = '{vld: w_accept, first: w_first, last: in_last};

   assign dsp_a        = in_a;
   assign dsp_b        = in_b;
   assign dsp_cea      = w_accept;
   assign dsp_ceb      = w_accept;
   assign dsp_cem      = w_tok[0].vld;
   assign dsp_ceopmode = w_tok[0].vld;
   assign dsp_cep      = w_tok[TOK_STAGES-1].vld;
   assign dsp_opmode   = r_opmode;

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_len   = r_out_len;

   // The OPMODE choice is made at accept time, so these token bits have no reader.
   assign w_unused_tok = ^{w_tok[0].first, w_tok[0].last, w_tok[TOK_STAGES-1].first};

   dsp_mac_token_pipe #(
      .STAGES (TOK_STAGES)
   ) u_tok_pipe (
      .CLK   (CLK),
      .RST   (RST),
      .i_tok (w_tok_in),
      .o_tok (w_tok)
   );

   // Next-state logic: collect pairs, wait for the last token to reach P, hold result.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = in_last ? S_DRAIN : S_ACCUM;
         end
         S_ACCUM: begin
            if (w_accept && in_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_cap_p2) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; ready follows the state being entered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
      end
   end

   // OPMODE for the slot after accept: first pair restarts the sum with Z=0.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_opmode <= 8'h00;
      end else if (w_accept) begin
         r_opmode <= w_tok_in.first ? OPM_MUL_ONLY : OPM_MUL_ACC;
      end
   end

   // Pair counter: restarts at 1 on a vector's first pair and saturates.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_count <= '0;
      end else if (w_accept) begin
         r_count <= w_first ? LEN_W'(1) : sat_inc(r_count);
      end
   end

   // Flags the cycle in which P already contains the last pair's contribution.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cap_p2 <= 1'b0;
      end else begin
         r_cap_p2 <= w_tok[TOK_STAGES-1].vld & w_tok[TOK_STAGES-1].last;
      end
   end

   // Result register: capture P once, hold it until the consumer takes it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_len   <= '0;
      end else if ((r_state == S_DRAIN) && r_cap_p2) begin
         r_out_valid <= 1'b1;
         r_out_data  <= dsp_p;
         r_out_len   <= r_count;
      end else if ((r_state == S_HOLD) && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
